tick_event_timer: RTL and testbench
===================================

Name: tick_event_timer

Overview:
Consumes the divided clock from the clock divider as a plain data signal and keeps the whole design on the fast clock. It synchronises the divided clock into the fast domain and turns each of its rising edges into a one-cycle tick. It also provides a programmable countdown timer on that tick, with one-shot and periodic modes. The timer emits a one-cycle expiry pulse, which control logic uses as a slow, glitch-free timebase event.

Parameters:
WIDTH, 16, width of load value, reload register and count.
SYNC_STAGES, 2, synchroniser flop count on slow_clk_in; legal values are 2 or more.

Ports:
clk  input  1  fast system clock; the same clock that feeds the divider.
rst  input  1  reset, asynchronous, active-low.
slow_clk_in  input  1  divided clock from clock divider; treated as async data.
start  input  1  level-sampled command: begin or resume counting.
stop  input  1  level-sampled command: pause counting.
load  input  1  level-sampled command: capture load_value.
load_value  input  WIDTH  new count / reload value.
periodic  input  1  1 = auto-reload on expiry; 0 = one-shot.
irq_clr  input  1  clears sticky irq (optional feature only).
tick  output  1  one-cycle pulse per slow_clk_in rising edge.
count  output  WIDTH  current count.
running  output  1  high while state is RUN.
expired  output  1  one-cycle pulse on terminal count.
irq  output  1  sticky interrupt flag (optional feature only).

Behaviour:
- Reset (rst low, async): all synchroniser flops 0, edge-history flop 0, tick 0, count 0, reload_reg 0, state IDLE, running 0, expired 0, irq 0.
- Synchroniser:
  - slow_clk_in passes through SYNC_STAGES flops, then an edge-history flop.
  - tick is registered: tick = synced & ~history.
  - With SYNC_STAGES=2, a rise that meets setup at clk edge N gives tick high for the cycle after edge N+2.
  - Falling edges produce no tick.
  - slow_clk_in high and low phases must each last at least SYNC_STAGES+1 clk cycles.
- States: IDLE, RUN, PAUSED, EXPIRED. Command priority: stop > load > start.
- load:
  - In IDLE, PAUSED or EXPIRED: reload_reg and count both take load_value next edge; state unchanged.
  - In RUN: only reload_reg updates; count untouched.
- start (IDLE, PAUSED, EXPIRED):
  - count != 0: go to RUN.
  - count == 0 and reload_reg != 0: count <= reload_reg, go to RUN.
  - count == 0 and reload_reg == 0: ignored.
  - start in RUN: no effect.
- stop:
  - In RUN: go to PAUSED; count held.
  - Tick in the same cycle as stop is discarded; count is not decremented.
  - stop in any other state: no effect.
- RUN, on tick:
  - count > 1: count <= count-1.
  - count == 1: expired pulses for one cycle, aligned with the count update.
    - periodic=1: count <= reload_reg; stay RUN.
    - periodic=0: count <= 0; go to EXPIRED.
  - If load coincides with the expiry tick in periodic mode, the reload uses the new load_value.
- running is registered and equals (state==RUN).
- expired never pulses outside RUN.
- Arithmetic is unsigned WIDTH-bit; count never wraps below 0.
- Reset mid-operation: immediate return to reset values; any in-flight tick is lost.

Optional Feature:
Macro TIMER_STICKY_IRQ_EN.
- Defined:
  - irq sets on the cycle expired pulses and stays high until irq_clr is sampled high.
  - When set and clear coincide, set wins.
  - irq resets to 0.
- Not defined:
  - irq is tied to 0 and irq_clr is ignored.
  - Both ports remain present, so the port list is identical in both builds.

Test Plan:
1. Reset release, then slow_clk_in toggled every 4 clk cycles -> one tick per rise, 3 cycles after the rise; no tick on falls; count stays 0 in IDLE.
2. load_value=3, load, start, periodic=0 -> count 3,2,1,0 on successive ticks; expired high exactly one cycle with count->0; state EXPIRED; running 0.
3. load_value=2, periodic=1, start -> count 2,1,2,1,2; expired pulses on every second tick; running stays 1.
4. load_value=5, run 2 ticks (count=3), assert stop on a tick cycle -> count stays 3, PAUSED; start -> next tick gives count 2.
5. RUN periodic, count=1, load_value=7 with load coincident with tick -> expired pulses and count becomes 7; load_value=0 with start in IDLE and reload_reg 0 -> stays IDLE.
6. With TIMER_STICKY_IRQ_EN: expiry -> irq=1 and held; irq_clr coincident with a new expiry -> irq stays 1; lone irq_clr -> irq=0; rst low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tick_event_timer.sv
// Synchronises a divided clock into the fast domain as a tick and runs a one-shot/periodic countdown on it.
// Build option: define TIMER_STICKY_IRQ_EN to enable the sticky irq flag (irq_clr clears it).
module tick_event_timer #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk_in,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             irq_clr,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;

  // slow_clk_in is asynchronous data; only the last stage feeds the edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    case (state_q)
      RUN: begin
        if (stop) begin
          // Pausing swallows any tick arriving in the same cycle.
          state_d = PAUSED;
        end else begin
          if (load) begin
            reload_d = load_value;
          end
          if (tick_q) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              expired_d = 1'b1;
              if (periodic) begin
                // reload_d already reflects a coincident load.
                count_d = reload_d;
              end else begin
                count_d = ZERO;
                state_d = EXPIRED;
              end
            end
          end
        end
      end
      default: begin
        if (load) begin
          reload_d = load_value;
          count_d  = load_value;
        end else if (start) begin
          if (count_q != ZERO) begin
            state_d = RUN;
          end else if (reload_q != ZERO) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
      end
    endcase
    running_d = (state_d == RUN);
  end

`ifdef TIMER_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over a simultaneous clear.
  always_comb begin
    irq_d = expired_d | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

  assign tick    = tick_q;
  assign count   = count_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_tick_event_timer.sv
// Directed table-driven bench for tick_event_timer: one table row per transaction, checked after its last clock.
module tb_tick_event_timer;

`ifdef TIMER_STICKY_IRQ_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        slow_clk_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        periodic = 1'b0;
  logic        irq_clr = 1'b0;
  logic        tick;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic        irq;

  int checks = 0;
  int errors = 0;

  tick_event_timer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .slow_clk_in(slow_clk_in),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .periodic   (periodic),
    .irq_clr    (irq_clr),
    .tick       (tick),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          slow;
    bit          st;
    bit          sp;
    bit          ld;
    logic [15:0] lv;
    bit          per;
    bit          clr;
    int          n;
    bit          e_tick;
    logic [15:0] e_count;
    bit          e_run;
    bit          e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit slow, input bit st, input bit sp, input bit ld, input int lv,
                     input bit per, input bit clr, input int n,
                     input bit et, input int ec, input bit er, input bit ee);
    vec_t v;
    v.slow = slow; v.st = st; v.sp = sp; v.ld = ld; v.lv = 16'(lv);
    v.per = per; v.clr = clr; v.n = n;
    v.e_tick = et; v.e_count = 16'(ec); v.e_run = er; v.e_exp = ee;
    vecs.push_back(v);
  endtask

  // One slow_clk_in period (rise held 4 cycles, low 4). Tick shows on the second row;
  // its effect (and any stop/load/clr sampled with it) shows on the third.
  task automatic tc(input bit per, input int cb, input int ca, input bit rb, input bit ra,
                    input bit ea, input bit sp = 0, input bit ld = 0, input int lv = 0,
                    input bit clr = 0);
    add(1, 0, 0,  0,  0,  per, 0,   2, 0, cb, rb, 0);
    add(1, 0, 0,  0,  0,  per, 0,   1, 1, cb, rb, 0);
    add(1, 0, sp, ld, lv, per, clr, 1, 0, ca, ra, ea);
    add(0, 0, 0,  0,  0,  per, 0,   4, 0, ca, ra, 0);
  endtask

  initial begin
    vec_t v;
    bit   irq_m;
    irq_m = 1'b0;

    // Ticks in IDLE: one per rise, none on falls, count untouched.
    tc(0, 0, 0, 0, 0, 0);
    tc(0, 0, 0, 0, 0, 0);
    // One-shot from 3.
    add(0, 0, 0, 1, 3, 0, 0, 1, 0, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0);
    tc(0, 3, 2, 1, 1, 0);
    tc(0, 2, 1, 1, 1, 0);
    tc(0, 1, 0, 1, 0, 1);
    tc(0, 0, 0, 0, 0, 0);
    // start from EXPIRED with count 0 reloads 3; stop pauses.
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    // Periodic from 2.
    add(0, 0, 0, 1, 2, 1, 0, 1, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 2, 1, 0);
    tc(1, 2, 1, 1, 1, 0);
    tc(1, 1, 2, 1, 1, 1);
    tc(1, 2, 1, 1, 1, 0);
    tc(1, 1, 2, 1, 1, 1);
    // Stop coincident with a tick.
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, 2, 0, 0);
    add(0, 0, 0, 1, 5, 0, 0, 1, 0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 5, 1, 0);
    tc(0, 5, 4, 1, 1, 0);
    tc(0, 4, 3, 1, 1, 0);
    tc(0, 3, 3, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0);
    tc(0, 3, 2, 1, 1, 0);
    // Load coincident with a periodic expiry reloads the new value.
    tc(1, 2, 1, 1, 1, 0);
    tc(1, 1, 7, 1, 1, 1, 0, 1, 7);
    tc(1, 7, 6, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, 6, 0, 0);
    // Zero count and zero reload: start ignored, ticks ignored.
    add(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tc(1, 0, 0, 0, 0, 0);
    // Sticky irq: periodic reload of 1 expires on every tick.
    add(0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0);
    tc(1, 1, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 1, 0);
    tc(1, 1, 1, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_expired", 32'(expired), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    $display("reset: tick=%0b count=%0d running=%0b expired=%0b irq=%0b", tick, count, running, expired, irq);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      slow_clk_in = v.slow;
      start       = v.st;
      stop        = v.sp;
      load        = v.ld;
      load_value  = v.lv;
      periodic    = v.per;
      irq_clr     = v.clr;
      repeat (v.n) begin
        @(posedge clk);
        #1;
      end
      irq_m = STICKY & (v.e_exp | (irq_m & ~v.clr));
      chk($sformatf("row%0d_tick", i), 32'(tick), 32'(v.e_tick));
      chk($sformatf("row%0d_count", i), 32'(count), 32'(v.e_count));
      chk($sformatf("row%0d_running", i), 32'(running), 32'(v.e_run));
      chk($sformatf("row%0d_expired", i), 32'(expired), 32'(v.e_exp));
      chk($sformatf("row%0d_irq", i), 32'(irq), 32'(irq_m));
      $display("row %0d: slow=%0b st=%0b sp=%0b ld=%0b lv=%0d per=%0b clr=%0b -> tick=%0b count=%0d running=%0b expired=%0b irq=%0b",
               i, v.slow, v.st, v.sp, v.ld, v.lv, v.per, v.clr, tick, count, running, expired, irq);
    end
    start = 1'b0; stop = 1'b0; load = 1'b0; irq_clr = 1'b0;

    // Asynchronous reset mid-RUN: outputs clear before the next clock edge.
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_expired", 32'(expired), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    $display("async reset: tick=%0b count=%0d running=%0b expired=%0b irq=%0b", tick, count, running, expired, irq);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_running", 32'(running), 32'd0);
    $display("after reset release: count=%0d running=%0b", count, running);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
